// File: rtl/inter_pkg.sv
// Shared widths and FSM state encoding for the interconnect slave memory controller.
package inter_pkg;

    localparam int ADDR_W = 3;
    localparam int VAL_W  = 3;
    localparam int DEPTH  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY,
        S_HOLD
    } slave_state_e;

endpackage

// File: rtl/slave_mem_ctrl_if.sv
// Request/accept bundle between the interconnect (master side) and a slave port.
interface slave_mem_ctrl_if;
    import inter_pkg::*;

    logic              valid;
    logic [ADDR_W-1:0] addr_in;
    logic [VAL_W-1:0]  value_in;
    logic              ready;

    modport master (
        output valid,
        output addr_in,
        output value_in,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr_in,
        input  value_in,
        output ready
    );

endinterface

// File: rtl/slave_regfile.sv
// 8 x 3-bit register file: one write port, synchronous clear, registered read-before-write port.
module slave_regfile
    import inter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [VAL_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [VAL_W-1:0]  rd_data
);

    logic [VAL_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            mem <= '{default: '0};
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads the pre-edge contents, so a same-edge write is not yet visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/slave_mem_ctrl.sv
// Slave port controller: waits WAIT_CYC cycles before accepting, stores accepted transfers, counts them.
module slave_mem_ctrl
    import inter_pkg::*;
#(
    parameter int WAIT_CYC = 2,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    slave_mem_ctrl_if.slave    bus,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [VAL_W-1:0]   rd_data,
    output logic [CNT_W-1:0]   wr_count
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

    slave_state_e state;
    logic [3:0]   cnt;
    logic         handshake;
    logic         wr_en;

    assign handshake = (state == S_READY) && bus.valid;
    assign wr_en     = handshake && !clear;

    // ready is registered alongside the state so it always equals (state == S_READY).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bus.ready <= 1'b0;
            wr_count  <= '0;
        end else begin
            if (clear) begin
                wr_count <= '0;
            end else if (handshake) begin
                wr_count <= wr_count + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (bus.valid) begin
                        if (WAIT_CYC == 0) begin
                            state     <= S_READY;
                            bus.ready <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.valid) begin
                        state <= S_IDLE;
                    end else if (cnt == WAIT_LAST) begin
                        state     <= S_READY;
                        bus.ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_READY: begin
                    bus.ready <= 1'b0;
                    state     <= bus.valid ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    bus.ready <= 1'b0;
                end
            endcase
        end
    end

    slave_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_addr (bus.addr_in),
        .wr_data (bus.value_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_slave_mem_ctrl.sv
// Directed bench for slave_mem_ctrl: WAIT_CYC=2/CNT_W=8 instance and WAIT_CYC=0/CNT_W=2 instance.
module tb_slave_mem_ctrl;
    import inter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slave_mem_ctrl_if bus_a ();
    slave_mem_ctrl_if bus_b ();

    logic       clear_a, clear_b;
    logic [2:0] rd_addr_a, rd_addr_b;
    logic [2:0] rd_data_a, rd_data_b;
    logic [7:0] wr_count_a;
    logic [1:0] wr_count_b;

    slave_mem_ctrl #(.WAIT_CYC(2), .CNT_W(8)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_a),
        .clear    (clear_a),
        .rd_addr  (rd_addr_a),
        .rd_data  (rd_data_a),
        .wr_count (wr_count_a)
    );

    slave_mem_ctrl #(.WAIT_CYC(0), .CNT_W(2)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_b),
        .clear    (clear_b),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .wr_count (wr_count_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.valid = 1'b0; bus_a.addr_in = '0; bus_a.value_in = '0;
        bus_b.valid = 1'b0; bus_b.addr_in = '0; bus_b.value_in = '0;
        clear_a = 1'b0; clear_b = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;

        tick();
        tick();
        check("rst_ready_a", bus_a.ready, 0);
        check("rst_count_a", wr_count_a, 0);
        check("rst_rd_a", rd_data_a, 0);
        check("rst_ready_b", bus_b.ready, 0);
        check("rst_count_b", wr_count_b, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_ready_a", bus_a.ready, 0);
            check("idle_count_a", wr_count_a, 0);
            check("idle_rd_a", rd_data_a, 0);
            check("idle_ready_b", bus_b.ready, 0);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(i);
            tick();
            check("init_mem_a", rd_data_a, 0);
            check("init_mem_b", rd_data_b, 0);
        end

        // First transfer: addr 5 <= 6, ready after E2, handshake at E3.
        rd_addr_a = 3'd5;
        bus_a.valid = 1'b1; bus_a.addr_in = 3'd5; bus_a.value_in = 3'd6;
        tick(); check("t1_e0_ready", bus_a.ready, 0);
        tick(); check("t1_e1_ready", bus_a.ready, 0);
        tick(); check("t1_e2_ready", bus_a.ready, 1);
        check("t1_e2_count", wr_count_a, 0);
        tick(); check("t1_e3_ready", bus_a.ready, 0);
        check("t1_e3_count", wr_count_a, 1);
        check("t1_e3_rd_old", rd_data_a, 0);
        bus_a.value_in = 3'd1;
        tick(); check("hold_ready", bus_a.ready, 0);
        check("hold_count", wr_count_a, 1);
        check("hold_rd", rd_data_a, 6);
        bus_a.valid = 1'b0;
        tick(); check("post_hold_ready", bus_a.ready, 0);
        check("post_hold_count", wr_count_a, 1);
        check("post_hold_rd", rd_data_a, 6);

        // Valid held continuously: handshakes at E3 and E8 (spacing WAIT_CYC+3).
        rd_addr_a = 3'd1;
        bus_a.valid = 1'b1; bus_a.addr_in = 3'd1; bus_a.value_in = 3'd7;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("space_ready", bus_a.ready, (k == 2 || k == 7) ? 1 : 0);
            if (k == 3) check("space_count1", wr_count_a, 2);
            if (k == 8) bus_a.valid = 1'b0;
        end
        check("space_count2", wr_count_a, 3);
        check("space_rd", rd_data_a, 7);

        // Request withdrawn while waiting.
        bus_a.valid = 1'b1; bus_a.addr_in = 3'd3; bus_a.value_in = 3'd2;
        rd_addr_a = 3'd3;
        tick(); check("drop_e0_ready", bus_a.ready, 0);
        bus_a.valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drop_ready", bus_a.ready, 0);
        end
        check("drop_count", wr_count_a, 3);
        check("drop_rd", rd_data_a, 0);

        // Clear on the handshake edge wins over the write.
        bus_a.valid = 1'b1; bus_a.addr_in = 3'd2; bus_a.value_in = 3'd3;
        tick(); tick(); tick();
        check("clr_ready", bus_a.ready, 1);
        clear_a = 1'b1;
        tick(); check("clr_e3_ready", bus_a.ready, 0);
        check("clr_e3_count", wr_count_a, 0);
        clear_a = 1'b0; bus_a.valid = 1'b0;
        tick(); check("clr_e4_ready", bus_a.ready, 0);
        check("clr_e4_count", wr_count_a, 0);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            tick();
            check("clr_mem", rd_data_a, 0);
        end

        // Reset while ready is high: no write, ready drops.
        bus_a.valid = 1'b1; bus_a.addr_in = 3'd4; bus_a.value_in = 3'd5;
        tick(); tick(); tick();
        check("rstrdy_ready", bus_a.ready, 1);
        rst_n = 1'b0;
        tick(); check("rstrdy_low", bus_a.ready, 0);
        rst_n = 1'b1; bus_a.valid = 1'b0; rd_addr_a = 3'd4;
        tick(); tick();
        check("rstrdy_rd", rd_data_a, 0);
        check("rstrdy_count", wr_count_a, 0);
        check("rstrdy_ready2", bus_a.ready, 0);

        // WAIT_CYC=0, CNT_W=2: four transfers, count wraps to 0.
        for (int i = 0; i < 4; i++) begin
            bus_b.valid = 1'b1; bus_b.addr_in = 3'(i); bus_b.value_in = 3'(i + 1);
            tick(); check("b_ready_e0", bus_b.ready, 1);
            tick(); check("b_ready_e1", bus_b.ready, 0);
            check("b_count", wr_count_b, (i + 1) % 4);
            bus_b.valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr_b = 3'(i);
            tick();
            check("b_mem", rd_data_b, i + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_mem_ctrl.md
# slave_mem_ctrl

Downstream slave for the 3-master/2-slave interconnect; one instance sits on each slave port. It consumes the interconnect's `valid` / `addr` / `value` triple and answers with a registered `ready` after a programmable wait. Each accepted transfer is written into an 8-entry × 3-bit register file. Contents and a write counter are exposed for the testbench and for downstream consumers.

## Interface
- `WAIT_CYC`, default 2: cycles between first sampling `valid` and asserting `ready`. Legal range 0..15.
- `CNT_W`, default 8: width of `wr_count`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `valid`  in  1  transfer request from interconnect (`valid_slaveN`).
- `addr_in`  in  3  target entry (`addr_out`).
- `value_in`  in  3  write data (`value_out`).
- `ready`  out  1  slave accepts; registered.
- `clear`  in  1  synchronous clear of register file and `wr_count`.
- `rd_addr`  in  3  read-port address.
- `rd_data`  out  3  `mem[rd_addr]`, registered.
- `wr_count`  out  `CNT_W`  accepted-transfer count, wraps modulo 2^`CNT_W`.

## Operation
- FSM states and transitions:
  - `S_IDLE`: if `valid`, go to `S_WAIT` with `cnt`=0. If `WAIT_CYC`==0, go straight to `S_READY`.
  - `S_WAIT`: `cnt`++ each cycle. When `cnt`==`WAIT_CYC`-1, go to `S_READY`. If `valid` drops, return to `S_IDLE`; no write.
  - `S_READY`: `ready`=1. If `valid` is sampled high, that cycle is the handshake:
    - `mem[addr_in]` <= `value_in` and `wr_count`++.
    - Go to `S_HOLD`.
    - If `valid` is low, go to `S_IDLE` (request withdrawn, no write).
  - `S_HOLD`: one cycle. `valid` is ignored, because the interconnect keeps `valid` high one cycle past the accepting edge. Then go to `S_IDLE`.
- `ready` = (state == `S_READY`), decoded from the state flop only; it never depends combinationally on inputs.
- Write data and address are sampled on the handshake edge only.
- Writes overwrite; no accumulation.
- Read port:
  - `rd_data` <= `mem[rd_addr]` each cycle.
  - A same-cycle write to `rd_addr` returns the old value (read-before-write).
- `clear`:
  - Zeroes all 8 entries and `wr_count` on the next edge.
  - Does not affect the FSM or `ready`.
  - Handshake and `clear` in the same cycle: `clear` wins, the write is dropped and the count is not incremented, but the FSM still goes to `S_HOLD`. The handshake is complete at the interface.
- `wr_count` wraps to 0 after 2^`CNT_W`-1.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State becomes `S_IDLE`; `cnt`=0.
  - `ready`=0, `rd_data`=0, `wr_count`=0, all `mem` entries 0.
  - Reset overrides `clear` and any handshake in progress.
  - Reset mid-`S_READY`: `ready` is low on the cycle after the edge, and no write occurs.
- `valid` first sampled at edge E0 means `ready` is high in the cycle after edge E`WAIT_CYC`, and the handshake occurs at edge E`WAIT_CYC`+1.
  - `WAIT_CYC`=0: `ready` is high after E0; handshake at E1.
- `ready` is high for exactly one cycle per completed transfer.
- Minimum spacing between handshakes: `WAIT_CYC`+3 edges.
- Write visible on `rd_data` two edges after the handshake edge: the write edge, then the read edge.

## Structure
- Package `inter_pkg` holds:
  - `ADDR_W`=3, `VAL_W`=3, `DEPTH`=8.
  - State enum `slave_state_e` {`S_IDLE`, `S_WAIT`, `S_READY`, `S_HOLD`}.
- Sub-module `slave_regfile`: 8×3 storage with write enable, sync clear, and registered read.
- `slave_mem_ctrl` holds the FSM, the wait counter and `wr_count`, and instantiates `slave_regfile`.

## Test plan
- Reset, then idle 5 cycles:
  - `ready`=0, `rd_data`=0 and `wr_count`=0 throughout.
  - All 8 addresses read back 0.
- `WAIT_CYC`=2, `valid`=1, `addr_in`=5, `value_in`=6, held until handshake:
  - `ready` high exactly in the cycle after E2.
  - `mem[5]`=6 and `wr_count`=1.
  - `rd_addr`=5 gives `rd_data`=6 two edges after the handshake.
- `valid` held high through `S_HOLD` with `addr_in`=5, `value_in`=1:
  - No second write; `mem[5]` stays 6, `wr_count` stays 1.
  - The next handshake is no earlier than E`WAIT_CYC`+3.
- `valid` dropped during `S_WAIT`:
  - FSM returns to `S_IDLE` and `ready` never rises.
  - `wr_count` unchanged.
- `clear` asserted on the handshake edge of `addr_in`=2, `value_in`=3:
  - All entries 0, `wr_count`=0.
  - `ready` deasserts normally.
- `CNT_W`=2, 4 back-to-back transfers to addresses 0..3 with values 1..4:
  - `wr_count` sequence 1, 2, 3, 0.
  - Entries 0..3 read back 1..4.
  - `WAIT_CYC`=0 variant: `ready` is high the cycle after E0.
